// File: rtl/mat_mul_pkg.sv
// mat_mul_pkg: shared state type and sizing/layout helpers for the matrix-multiply sequencer and its wrapper
package mat_mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mat_mul_state_t;
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k) + 1;
  endfunction
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // bit offset of element (r,col) in a row-major rows x cols matrix with element (0,0) in the MSBs
  function automatic int elem_off(input int rows, input int cols, input int r, input int col, input int dw);
    return (rows * cols - 1 - (r * cols + col)) * dw;
  endfunction
endpackage

// File: rtl/mat_mul_mac.sv
// mat_mul_mac: single multiply-accumulate lane, acc <= clr ? 0 : (en ? acc + x*y : acc)
//   clk, rstn (async active-low), clr (priority over en), en, x/y operands, acc accumulator
module mat_mul_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W = 18
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  output logic [ACC_W-1:0]      acc
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) acc <= '0;
    else acc <= clr ? '0 : (en ? acc + ACC_W'(x) * ACC_W'(y) : acc);
endmodule

// File: rtl/mat_mul_seq.sv
// mat_mul_seq: sequencer for C = A x B on one shared MAC lane, one product per cycle
//   clk, rstn (async active-low); in_valid/in_ready capture row-major a, b; c/out_valid/out_ready present C;
//   busy is high in RUN; counter holds RUN cycles of the last/current operation (saturating).
//   Define MAT_MUL_SAT_EN to saturate each C element instead of keeping its low DATA_WIDTH bits.
module mat_mul_seq
  import mat_mul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS_A = 2,
  parameter int COLS_A = 2,
  parameter int COLS_B = 2
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ROWS_A*COLS_A*DATA_WIDTH-1:0] a,
  input  logic [COLS_A*COLS_B*DATA_WIDTH-1:0] b,
  output logic [ROWS_A*COLS_B*DATA_WIDTH-1:0] c,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic [31:0]                         counter
);
  localparam int ACC_W = acc_width(DATA_WIDTH, COLS_A);
  localparam int IW = idx_width(ROWS_A);
  localparam int KW = idx_width(COLS_A);
  localparam int JW = idx_width(COLS_B);
  localparam int AW = ROWS_A * COLS_A * DATA_WIDTH;
  localparam int BW = COLS_A * COLS_B * DATA_WIDTH;
  localparam int CW = ROWS_A * COLS_B * DATA_WIDTH;
  localparam int AS = $clog2(AW);
  localparam int BS = $clog2(BW);
  localparam int CS = $clog2(CW);
  mat_mul_state_t state;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic [AW-1:0] a_q;
  logic [BW-1:0] b_q;
  logic [DATA_WIDTH-1:0] x, y, elem;
  logic [ACC_W-1:0] acc;
  logic accept, run, clr, k_last, j_last, i_last;
  assign accept = in_valid & in_ready;
  assign run = state == RUN;
  assign k_last = k == KW'(COLS_A - 1);
  assign j_last = j == JW'(COLS_B - 1);
  assign i_last = i == IW'(ROWS_A - 1);
  assign clr = accept | (run & k_last);
  assign x = a_q[AS'(elem_off(ROWS_A, COLS_A, int'(i), int'(k), DATA_WIDTH)) +: DATA_WIDTH];
  assign y = b_q[BS'(elem_off(COLS_A, COLS_B, int'(k), int'(j), DATA_WIDTH)) +: DATA_WIDTH];
  // the final product of a dot product is folded in here so C is written the same cycle the lane clears
`ifdef MAT_MUL_SAT_EN
  logic [ACC_W-1:0] sum;
  assign sum = acc + ACC_W'(x) * ACC_W'(y);
  assign elem = |sum[ACC_W-1:DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
`else
  assign elem = DATA_WIDTH'(acc + ACC_W'(x) * ACC_W'(y));
`endif
  mat_mul_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .rstn(rstn), .clr(clr), .en(run), .x(x), .y(y), .acc(acc)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      a_q <= '0;
      b_q <= '0;
      c <= '0;
      counter <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= !accept;
          if (accept) begin
            a_q <= a;
            b_q <= b;
            i <= '0;
            j <= '0;
            k <= '0;
            counter <= '0;
            busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          counter <= &counter ? counter : counter + 32'd1;
          if (k_last) begin
            c[CS'(elem_off(ROWS_A, COLS_B, int'(i), int'(j), DATA_WIDTH)) +: DATA_WIDTH] <= elem;
            k <= '0;
            j <= j_last ? '0 : j + JW'(1);
            i <= j_last ? (i_last ? '0 : i + IW'(1)) : i;
            if (i_last && j_last) begin
              busy <= 1'b0;
              out_valid <= 1'b1;
              state <= DONE;
            end
          end else k <= k + KW'(1);
        end
        DONE: begin
          // re-arming in_ready here lets the next accept land on the first IDLE cycle
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mat_mul_seq.sv
// tb_mat_mul_seq: self-checking bench for mat_mul_seq (2x2x2 default instance plus a 3x1x2 instance)
module tb_mat_mul_seq;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [31:0] a = '0, b = '0, c, counter;
  logic in_valid6 = 1'b0, out_ready6 = 1'b0;
  logic in_ready6, out_valid6, busy6;
  logic [23:0] a6 = '0;
  logic [15:0] b6 = '0;
  logic [47:0] c6;
  logic [31:0] counter6;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } vec_t;
  vec_t tbl[8];
  mat_mul_seq u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .counter(counter)
  );
  mat_mul_seq #(.DATA_WIDTH(8), .ROWS_A(3), .COLS_A(1), .COLS_B(2)) u_dut6 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid6), .in_ready(in_ready6), .a(a6), .b(b6), .c(c6),
    .out_valid(out_valid6), .out_ready(out_ready6), .busy(busy6), .counter(counter6)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // plain matrix arithmetic on 8-bit row-major operands, then the per-element reduction
  function automatic logic [63:0] ref_mm(input logic [63:0] av, input logic [63:0] bv, input int rr, input int kk, input int qq);
    logic [63:0] res;
    int s;
    res = '0;
    for (int r = 0; r < rr; r++)
      for (int q = 0; q < qq; q++) begin
        s = 0;
        for (int t = 0; t < kk; t++)
          s += int'(av[(rr*kk-1-(r*kk+t))*8 +: 8]) * int'(bv[(kk*qq-1-(t*qq+q))*8 +: 8]);
`ifdef MAT_MUL_SAT_EN
        s = (s > 255) ? 255 : s;
`else
        s = s % 256;
`endif
        res[(rr*qq-1-(r*qq+q))*8 +: 8] = 8'(s);
      end
    return res;
  endfunction
  function automatic logic [31:0] ref22(input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] r;
    r = ref_mm(64'(av), 64'(bv), 2, 2, 2);
    return r[31:0];
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // accept one operation on the 2x2x2 instance and wait for its result; lat counts cycles from accept to out_valid
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, output int lat);
    int t, ac;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'(1));
    a = av;
    b = bv;
    in_valid = 1'b1;
    ac = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid_wait", 64'(out_valid), 64'(1));
    lat = cyc - ac;
  endtask
  task automatic release_c();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  initial begin
    int lat, t, ac;
    logic [31:0] keep, av, bv, exp;
    logic [63:0] e6;
    tbl[0] = '{32'h0204_0607, 32'h0104_0709, 32'h1E2C_3757};
    tbl[1] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
    tbl[2] = '{32'h0100_0001, 32'h0506_0708, 32'h0506_0708};
`ifdef MAT_MUL_SAT_EN
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`else
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0202_0202};
`endif
    for (int n = 4; n < 8; n++) begin
      tbl[n].a = $urandom();
      tbl[n].b = (n == 7) ? $urandom() & 32'h0F0F_0F0F : $urandom();
      tbl[n].c = ref22(tbl[n].a, tbl[n].b);
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_c", 64'(c), 64'(0));
    chk("rst_counter", 64'(counter), 64'(0));
    rstn = 1'b1;
    issue(tbl[0].a, tbl[0].b, lat);
    chk("t1_c", 64'(c), 64'(32'h1E2C_3757));
    chk("t1_lat", 64'(lat), 64'(9));
    chk("t1_counter", 64'(counter), 64'(8));
    chk("t1_busy", 64'(busy), 64'(0));
    keep = c;
    a = 32'h0101_0101;
    b = 32'h0101_0101;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("hold_c", 64'(c), 64'(keep));
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      chk("hold_counter", 64'(counter), 64'(8));
    end
    in_valid = 1'b0;
    release_c();
    chk("exit_valid", 64'(out_valid), 64'(0));
    chk("exit_in_ready", 64'(in_ready), 64'(1));
    chk("exit_busy", 64'(busy), 64'(0));
    chk("exit_c", 64'(c), 64'(keep));
    @(negedge clk);
    chk("exit_no_accept", 64'(busy), 64'(0));
    for (int n = 0; n < 8; n++) begin
      issue(tbl[n].a, tbl[n].b, lat);
      chk("tbl_c", 64'(c), 64'(tbl[n].c));
      chk("tbl_lat", 64'(lat), 64'(9));
      chk("tbl_counter", 64'(counter), 64'(8));
      release_c();
    end
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    a = tbl[0].a;
    b = tbl[0].b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'(1));
    rstn = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_c", 64'(c), 64'(0));
    chk("abort_counter", 64'(counter), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    issue(tbl[0].a, tbl[0].b, lat);
    chk("after_abort_c", 64'(c), 64'(32'h1E2C_3757));
    chk("after_abort_counter", 64'(counter), 64'(8));
    release_c();
    av = $urandom();
    bv = $urandom();
    exp = ref22(av, bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    ac = cyc;
    for (int r = 0; r < 2; r++) begin
      t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("b2b_valid", 64'(out_valid), 64'(1));
      chk("b2b_lat", 64'(cyc - ac), 64'(9));
      chk("b2b_c", 64'(c), 64'(exp));
      chk("b2b_counter", 64'(counter), 64'(8));
      if (r == 1) in_valid = 1'b0;
      release_c();
      chk("b2b_idle_ready", 64'(in_ready), 64'(1));
      chk("b2b_idle_valid", 64'(out_valid), 64'(0));
      ac = cyc;
      if (r == 0) begin
        @(negedge clk);
        chk("b2b_reaccept", 64'(busy), 64'(1));
      end
    end
    @(negedge clk);
    chk("b2b_end_busy", 64'(busy), 64'(0));
    for (int n = 0; n < 3; n++) begin
      a6 = (n == 0) ? 24'h01_0203 : 24'($urandom());
      b6 = (n == 0) ? 16'h0405 : 16'($urandom());
      e6 = ref_mm(64'(a6), 64'(b6), 3, 1, 2);
      t = 0;
      while (!in_ready6 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("p6_in_ready", 64'(in_ready6), 64'(1));
      in_valid6 = 1'b1;
      ac = cyc;
      @(negedge clk);
      in_valid6 = 1'b0;
      t = 0;
      while (!out_valid6 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("p6_valid", 64'(out_valid6), 64'(1));
      chk("p6_lat", 64'(cyc - ac), 64'(7));
      chk("p6_counter", 64'(counter6), 64'(6));
      chk("p6_c", 64'(c6), e6);
      if (n == 0) chk("p6_c_order", 64'(c6), 64'(48'h0405_080A_0C0F));
      out_ready6 = 1'b1;
      @(negedge clk);
      out_ready6 = 1'b0;
      chk("p6_exit_valid", 64'(out_valid6), 64'(0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
